// File: rtl/div16x8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package div_pkg;

    localparam int unsigned YW = 8;
    localparam int unsigned XW = 16;
    localparam int unsigned CW = $clog2(YW);

    // Quotient/remainder pattern reported for divide-by-zero and quotient overflow
    localparam logic [YW-1:0] ERR_Q = {YW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div16x8_seq_ctrl_sub_row8.sv
// One restoring-division row: (YW+1)-bit partial remainder minus YW-bit divisor,
// with restore mux. Purely combinational; the controller reuses it every cycle.
module sub_row8 #(
    parameter int unsigned YW = 8
) (
    input  logic [YW:0]   pr_i,
    input  logic [YW-1:0] y_i,
    output logic [YW-1:0] rem_o,
    output logic          qbit_o
);
    import div_pkg::*;

    logic [YW:0] diff;
    logic        borrow;

    // Unsigned subtract; because the partial remainder is always below 2*y, the
    // MSB of the (YW+1)-bit difference is exactly the borrow. Either selected
    // value is below y, so the top bit can be dropped.
    always_comb begin
        diff   = pr_i - {1'b0, y_i};
        borrow = diff[YW];
        qbit_o = ~borrow;
        rem_o  = borrow ? pr_i[YW-1:0] : diff[YW-1:0];
    end

endmodule

// File: rtl/div16x8_seq_ctrl.sv
// Sequential 16/8 restoring divider controller: valid/ready operand intake,
// YW iterations through a single shared subtractor row, held result until accepted.
module div16x8_seq_ctrl #(
    parameter int unsigned YW = 8,
    parameter int unsigned XW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [YW-1:0] q,
    output logic [YW-1:0] r,
    output logic          dz,
    output logic          ovf,
    output logic          busy
);
    import div_pkg::*;

    localparam int unsigned CNT_W = (YW > 1) ? $clog2(YW) : 1;

    if (XW != 2 * YW) begin : g_width_check
        $error("div16x8_seq_ctrl: XW must equal 2*YW");
    end

    state_t          state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [YW-1:0]   x_lo_q, x_lo_d;
    logic [YW-1:0]   y_q, y_d;
    logic [YW-1:0]   rem_q, rem_d;
    logic [YW-1:0]   q_acc_q, q_acc_d;
    logic [YW-1:0]   q_out_q, q_out_d;
    logic [YW-1:0]   r_out_q, r_out_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;

    logic [YW:0]     row_pr;
    logic [YW-1:0]   row_rem;
    logic            row_qbit;

    // Only the low dividend half is kept: the high half seeds the remainder at
    // accept time, and the low half supplies one bit per iteration, MSB first.
    assign row_pr = {rem_q, x_lo_q[count_q]};

    sub_row8 #(.YW(YW)) u_row (
        .pr_i   (row_pr),
        .y_i    (y_q),
        .rem_o  (row_rem),
        .qbit_o (row_qbit)
    );

    // Next-state and datapath update for IDLE/RUN/DONE
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_lo_d  = x_lo_q;
        y_d     = y_q;
        rem_d   = rem_q;
        q_acc_d = q_acc_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_lo_d = x[YW-1:0];
                    y_d    = y;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    if (y == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                        q_out_d = '1;
                        r_out_d = '1;
                    end else if (x[XW-1:YW] >= y) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        q_out_d = '1;
                        r_out_d = '1;
                    end else begin
                        state_d = RUN;
                        rem_d   = x[XW-1:YW];
                        count_d = CNT_W'(YW - 1);
                        q_acc_d = '0;
                    end
                end
            end
            RUN: begin
                rem_d   = row_rem;
                q_acc_d = {q_acc_q[YW-2:0], row_qbit};
                if (count_q == '0) begin
                    state_d = DONE;
                    q_out_d = {q_acc_q[YW-2:0], row_qbit};
                    r_out_d = row_rem;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            x_lo_q  <= '0;
            y_q     <= '0;
            rem_q   <= '0;
            q_acc_q <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_lo_q  <= x_lo_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            q_acc_q <= q_acc_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign q         = q_out_q;
    assign r         = r_out_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_div16x8_seq_ctrl.sv
// Self-checking bench for div16x8_seq_ctrl against an x/y, x%y arithmetic model.
module tb_div16x8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
    logic        busy;

    int errors = 0;
    int checks = 0;

    div16x8_seq_ctrl #(.YW(8), .XW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division with the error rules
    function automatic void model(input logic [15:0] xv, input logic [7:0] yv,
                                  output logic [7:0] eq, output logic [7:0] er,
                                  output logic edz, output logic eovf);
        int unsigned xi;
        int unsigned yi;
        xi   = xv;
        yi   = yv;
        edz  = 1'b0;
        eovf = 1'b0;
        if (yi == 0) begin
            edz = 1'b1; eq = 8'hFF; er = 8'hFF;
        end else if (xi / yi > 255) begin
            eovf = 1'b1; eq = 8'hFF; er = 8'hFF;
        end else begin
            eq = 8'(xi / yi); er = 8'(xi % yi);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation and collect the result; lat counts edges after the accept edge
    task automatic run_op(input logic [15:0] xv, input logic [7:0] yv, input int unsigned stall,
                          output logic [7:0] oq, output logic [7:0] orr,
                          output logic odz, output logic oovf,
                          output int lat, output bit to);
        int n;
        to = 1'b0; lat = 0; n = 0;
        oq = '0; orr = '0; odz = 1'b0; oovf = 1'b0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) begin to = 1'b1; return; end
        x = xv; y = yv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x = 16'($urandom);
        y = 8'($urandom);
        while (!out_valid && lat < 40) begin tick(); lat++; end
        if (!out_valid) begin to = 1'b1; return; end
        repeat (stall) tick();
        oq = q; orr = r; odz = dz; oovf = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (q !== 8'h00)        begin errors++; $display("FAIL reset_q: got %h expected 00", q); end
        checks++; if (r !== 8'h00)        begin errors++; $display("FAIL reset_r: got %h expected 00", r); end
        checks++; if ({dz, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {dz, ovf}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] dx [8] = '{16'd8, 16'd199, 16'd127, 16'd40, 16'hFEFF, 16'h0500, 16'd100, 16'd20};
        logic [7:0]  dy [8] = '{8'd4, 8'd7,    8'd5,    8'd13,  8'hFF,    8'd5,     8'd0,   8'd5};
        logic [7:0] gq, gr, eq, er;
        logic gdz, govf, edz, eovf;
        int lat, elat;
        bit to;
        for (int i = 0; i < 8; i++) begin
            model(dx[i], dy[i], eq, er, edz, eovf);
            elat = (edz || eovf) ? 0 : 8;
            run_op(dx[i], dy[i], 0, gq, gr, gdz, govf, lat, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir_timeout[%0d]: got timeout expected result", i); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, elat); end
            checks++; if (gq !== eq) begin errors++; $display("FAIL dir_q[%0d] x=%h y=%h: got %h expected %h", i, dx[i], dy[i], gq, eq); end
            checks++; if (gr !== er) begin errors++; $display("FAIL dir_r[%0d] x=%h y=%h: got %h expected %h", i, dx[i], dy[i], gr, er); end
            checks++; if ({gdz, govf} !== {edz, eovf}) begin errors++; $display("FAIL dir_flags[%0d]: got dz,ovf=%b expected %b", i, {gdz, govf}, {edz, eovf}); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        x = 16'd40; y = 8'd13; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        in_valid = 1'b1; x = 16'd1234; y = 8'd3;
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL run_in_ready: got %b expected 0", in_ready); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL run_busy: got %b expected 1", busy); end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: got out_valid %b expected 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if ({q, r} !== {8'd3, 8'd1}) begin errors++; $display("FAIL bp_hold_qr[%0d]: got q=%0d r=%0d expected q=3 r=1", i, q, r); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got valid,ready=%b expected 01", {out_valid, in_ready}); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] gq, gr;
        logic gdz, govf;
        int lat, seen, n;
        bit to;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        x = 16'd199; y = 8'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin errors++; $display("FAIL abort_ctrl: got ready,valid,busy=%b expected 100", {in_ready, out_valid, busy}); end
        checks++; if ({q, r} !== 16'h0000) begin errors++; $display("FAIL abort_qr: got q=%h r=%h expected 00 00", q, r); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result: got %0d valid cycles expected 0", seen); end
        run_op(16'd17, 8'd5, 0, gq, gr, gdz, govf, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL after_abort_timeout: got timeout expected result"); end
        checks++; if ({gq, gr} !== {8'd3, 8'd2}) begin errors++; $display("FAIL after_abort_qr: got q=%0d r=%0d expected q=3 r=2", gq, gr); end
        checks++; if ({gdz, govf} !== 2'b00) begin errors++; $display("FAIL after_abort_flags: got %b expected 00", {gdz, govf}); end
    endtask

    task automatic test_random(input int nops);
        logic [15:0] xv;
        logic [7:0] yv, gq, gr, eq, er;
        logic gdz, govf, edz, eovf;
        int lat, elat, mode;
        bit to;
        for (int i = 0; i < nops; i++) begin
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
                yv = 8'd0; xv = 16'($urandom);
            end else if (mode == 1) begin
                yv = 8'($urandom); xv = 16'($urandom);
            end else begin
                yv = 8'($urandom_range(1, 255));
                xv = 16'($urandom_range(0, int'(yv) * 256 - 1));
            end
            model(xv, yv, eq, er, edz, eovf);
            elat = (edz || eovf) ? 0 : 8;
            run_op(xv, yv, $urandom_range(0, 3), gq, gr, gdz, govf, lat, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd_timeout[%0d]: got timeout expected result", i); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, elat); end
            checks++; if ({gq, gr} !== {eq, er}) begin errors++; $display("FAIL rnd_qr[%0d] x=%h y=%h: got q=%h r=%h expected q=%h r=%h", i, xv, yv, gq, gr, eq, er); end
            checks++; if ({gdz, govf} !== {edz, eovf}) begin errors++; $display("FAIL rnd_flags[%0d] x=%h y=%h: got %b expected %b", i, xv, yv, {gdz, govf}, {edz, eovf}); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random(1500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
